// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: captures operands into ID/EX, bubbles on load-use and
// writeback conflicts. Define WB_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module id_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_valid,
   input  logic [DW-1:0] if_instr,
   input  logic [DW-1:0] if_pc,
   output logic          id_ready,
   output logic [AW-1:0] inst_read_reg_addr1,
   output logic [AW-1:0] inst_read_reg_addr2,
   input  logic [DW-1:0] reg_file_rd_data1,
   input  logic [DW-1:0] reg_file_rd_data2,
   input  logic          reg_wr,
   input  logic [AW-1:0] reg_wr_addr,
   input  logic [DW-1:0] reg_wr_data,
   input  logic          flush,
   input  logic          ex_ready,
   output logic          ex_valid,
   output logic [DW-1:0] ex_pc,
   output logic [DW-1:0] ex_rs_data,
   output logic [DW-1:0] ex_rt_data,
   output logic [DW-1:0] ex_imm,
   output logic [AW-1:0] ex_rs,
   output logic [AW-1:0] ex_rt,
   output logic [AW-1:0] ex_rd,
   output logic [5:0]    ex_opcode,
   output logic [5:0]    ex_funct,
   output logic          ex_reg_write,
   output logic          ex_mem_read
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_ex_valid;
   logic [DW-1:0] r_ex_pc, r_ex_rs_data, r_ex_rt_data, r_ex_imm;
   logic [AW-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
   logic [5:0]    r_ex_opcode, r_ex_funct;
   logic          r_ex_reg_write, r_ex_mem_read;

   logic [5:0]    w_opcode;
   logic [AW-1:0] w_rs, w_rt, w_rd, w_dest;
   logic          w_writes;
   logic          w_hold, w_hazard, w_wb_rs_hit, w_wb_rt_hit, w_wb_stall;
   logic          w_id_ready, w_load;
   logic [DW-1:0] w_rs_data, w_rt_data;
   logic          w_unused_shamt;

   assign w_opcode = if_instr[31:26];
   assign w_rs     = if_instr[25:21];
   assign w_rt     = if_instr[20:16];
   assign w_rd     = if_instr[15:11];
   assign w_dest   = (w_opcode == OP_RTYPE) ? w_rd : w_rt;
   assign w_unused_shamt = ^if_instr[10:6];

   assign inst_read_reg_addr1 = w_rs;
   assign inst_read_reg_addr2 = w_rt;

   assign w_writes = ((w_opcode == OP_RTYPE) || (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                      (w_opcode == OP_ORI)   || (w_opcode == OP_LUI)  || (w_opcode == OP_LW)) &&
                     (w_dest != REG_ZERO);

   assign w_hold   = r_ex_valid & ~ex_ready;
   assign w_hazard = r_ex_valid & r_ex_mem_read & (r_ex_rd != REG_ZERO) & if_valid &
                     ((r_ex_rd == w_rs) | (r_ex_rd == w_rt));

   assign w_wb_rs_hit = if_valid & reg_wr & (reg_wr_addr != REG_ZERO) & (reg_wr_addr == w_rs);
   assign w_wb_rt_hit = if_valid & reg_wr & (reg_wr_addr != REG_ZERO) & (reg_wr_addr == w_rt);

`ifdef WB_BYPASS_EN
   assign w_wb_stall = 1'b0;
   assign w_rs_data  = (w_rs == REG_ZERO) ? {DW{1'b0}} : (w_wb_rs_hit ? reg_wr_data : reg_file_rd_data1);
   assign w_rt_data  = (w_rt == REG_ZERO) ? {DW{1'b0}} : (w_wb_rt_hit ? reg_wr_data : reg_file_rd_data2);
`else
   // The register file data is stale while the write is in flight; wait one cycle for it to land.
   assign w_wb_stall = w_wb_rs_hit | w_wb_rt_hit;
   assign w_rs_data  = (w_rs == REG_ZERO) ? {DW{1'b0}} : reg_file_rd_data1;
   assign w_rt_data  = (w_rt == REG_ZERO) ? {DW{1'b0}} : reg_file_rd_data2;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // FSM next-state: flush wins, hold freezes, a stall enters BUBBLE, everything else runs
   always_comb begin
      w_state_nxt = r_state;
      if (flush)                         w_state_nxt = ST_RUN;
      else if (w_hold)                   w_state_nxt = r_state;
      else if (w_hazard || w_wb_stall)   w_state_nxt = ST_BUBBLE;
      else                               w_state_nxt = ST_RUN;
   end

   // FSM outputs: in BUBBLE the load has already left EX, so no load-use check applies
   always_comb begin
      w_id_ready = 1'b0;
      case (r_state)
         ST_RUN:    w_id_ready = ~w_hold & ~w_hazard & ~w_wb_stall;
         ST_BUBBLE: w_id_ready = ~w_hold & ~w_wb_stall;
         default:   w_id_ready = 1'b0;
      endcase
      w_load = w_id_ready & if_valid & ~flush;
   end

   // ID/EX pipeline register with held-operand writeback snoop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ex_valid     <= 1'b0;
         r_ex_pc        <= {DW{1'b0}};
         r_ex_rs_data   <= {DW{1'b0}};
         r_ex_rt_data   <= {DW{1'b0}};
         r_ex_imm       <= {DW{1'b0}};
         r_ex_rs        <= REG_ZERO;
         r_ex_rt        <= REG_ZERO;
         r_ex_rd        <= REG_ZERO;
         r_ex_opcode    <= 6'd0;
         r_ex_funct     <= 6'd0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_read  <= 1'b0;
      end else if (flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_hold) begin
         if (reg_wr && (reg_wr_addr != REG_ZERO) && (reg_wr_addr == r_ex_rs)) r_ex_rs_data <= reg_wr_data;
         if (reg_wr && (reg_wr_addr != REG_ZERO) && (reg_wr_addr == r_ex_rt)) r_ex_rt_data <= reg_wr_data;
      end else if (w_load) begin
         r_ex_valid     <= 1'b1;
         r_ex_pc        <= if_pc;
         r_ex_rs_data   <= w_rs_data;
         r_ex_rt_data   <= w_rt_data;
         r_ex_imm       <= {{(DW-16){if_instr[15]}}, if_instr[15:0]};
         r_ex_rs        <= w_rs;
         r_ex_rt        <= w_rt;
         r_ex_rd        <= w_dest;
         r_ex_opcode    <= w_opcode;
         r_ex_funct     <= if_instr[5:0];
         r_ex_reg_write <= w_writes;
         r_ex_mem_read  <= (w_opcode == OP_LW);
      end else begin
         r_ex_valid <= 1'b0;
      end
   end

   assign id_ready     = w_id_ready;
   assign ex_valid     = r_ex_valid;
   assign ex_pc        = r_ex_pc;
   assign ex_rs_data   = r_ex_rs_data;
   assign ex_rt_data   = r_ex_rt_data;
   assign ex_imm       = r_ex_imm;
   assign ex_rs        = r_ex_rs;
   assign ex_rt        = r_ex_rt;
   assign ex_rd        = r_ex_rd;
   assign ex_opcode    = r_ex_opcode;
   assign ex_funct     = r_ex_funct;
   assign ex_reg_write = r_ex_reg_write;
   assign ex_mem_read  = r_ex_mem_read;

endmodule
